// File: rtl/spi_reg_ctrl_if.sv
// SPI-byte and register-bus signal bundle for spi_reg_ctrl.
// Handshake: a byte transfers on every clk edge where spi_valid & spi_ready are both high; spi_tx_data is captured by the SPI slave on that same edge.
interface spi_reg_ctrl_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  spi_valid;
    logic                  spi_ready;
    logic [7:0]            spi_rx_data;
    logic [7:0]            spi_tx_data;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_wr_en;
    logic [7:0]            reg_wdata;
    logic                  reg_rd_en;
    logic [7:0]            reg_rdata;

    modport master (
        input  spi_valid, spi_rx_data, reg_rdata,
        output spi_ready, spi_tx_data, reg_addr, reg_wr_en, reg_wdata, reg_rd_en
    );

    modport slave (
        output spi_valid, spi_rx_data, reg_rdata,
        input  spi_ready, spi_tx_data, reg_addr, reg_wr_en, reg_wdata, reg_rd_en
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command-byte decoder bridging received SPI bytes to a simple register bus.
// Frame: {rw, addr} command byte, then write data bytes or dummy bytes clocking out read data.
module spi_reg_ctrl #(
    parameter int         ADDR_WIDTH = 7,
    parameter logic [7:0] IDLE_TX    = 8'h00
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               spi_ss_n,
    spi_reg_ctrl_if.master     bus,
    output logic               busy,
    output logic [2:0]         state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_WR        = 3'd2,
        S_RD_FETCH  = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_RD_STREAM = 3'd5
    } state_t;

    state_t                state, state_n;
    logic                  ss_meta, ss_s;
    logic [ADDR_WIDTH-1:0] addr, addr_n, reg_addr_n;
    logic [7:0]            tx_hold, tx_hold_n, tx_n, wdata_n;
    logic                  ready_n, wr_n, rd_n, busy_n, hs;

    assign hs        = bus.spi_valid & bus.spi_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ss_meta <= 1'b1;
            ss_s    <= 1'b1;
        end else begin
            ss_meta <= spi_ss_n;
            ss_s    <= ss_meta;
        end
    end

    // Outputs are registered from the next state, so they always describe the state being entered.
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        tx_hold_n  = tx_hold;
        reg_addr_n = bus.reg_addr;
        wdata_n    = bus.reg_wdata;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        if (ss_s) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_n = S_CMD;
                S_CMD: begin
                    if (hs) begin
                        addr_n  = ADDR_WIDTH'(bus.spi_rx_data[6:0]);
                        state_n = bus.spi_rx_data[7] ? S_RD_FETCH : S_WR;
                    end
                end
                S_WR: begin
                    if (hs) begin
                        wr_n       = 1'b1;
                        reg_addr_n = addr;
                        wdata_n    = bus.spi_rx_data;
                        addr_n     = addr + ADDR_WIDTH'(1);
                    end
                end
                S_RD_FETCH: state_n = S_RD_WAIT;
                S_RD_WAIT: begin
                    tx_hold_n = bus.reg_rdata;
                    addr_n    = addr + ADDR_WIDTH'(1);
                    state_n   = S_RD_STREAM;
                end
                S_RD_STREAM: begin
                    if (hs) state_n = S_RD_FETCH;
                end
                default: state_n = S_IDLE;
            endcase
        end
        if (state_n == S_RD_FETCH) begin
            rd_n       = 1'b1;
            reg_addr_n = addr_n;
        end
        ready_n = !((state_n == S_RD_FETCH) || (state_n == S_RD_WAIT));
        tx_n    = (state_n == S_RD_STREAM) ? tx_hold_n : IDLE_TX;
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            addr            <= '0;
            tx_hold         <= 8'h00;
            bus.spi_ready   <= 1'b0;
            bus.spi_tx_data <= IDLE_TX;
            bus.reg_addr    <= '0;
            bus.reg_wr_en   <= 1'b0;
            bus.reg_wdata   <= 8'h00;
            bus.reg_rd_en   <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_n;
            addr            <= addr_n;
            tx_hold         <= tx_hold_n;
            bus.spi_ready   <= ready_n;
            bus.spi_tx_data <= tx_n;
            bus.reg_addr    <= reg_addr_n;
            bus.reg_wr_en   <= wr_n;
            bus.reg_wdata   <= wdata_n;
            bus.reg_rd_en   <= rd_n;
            busy            <= busy_n;
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frame table, multi-cycle corner sequences and random frames
// checked against a frame-level model of the command protocol.
module tb_spi_reg_ctrl;
    localparam int         AW      = 7;
    localparam logic [7:0] IDLE_TX = 8'h5A;
    localparam int         BUDGET  = 50;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic       spi_ss_n = 1'b1;
    logic       busy;
    logic [2:0] state_dbg;

    spi_reg_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    spi_reg_ctrl #(.ADDR_WIDTH(AW), .IDLE_TX(IDLE_TX)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .spi_ss_n  (spi_ss_n),
        .bus       (bus.master),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [7:0]    regs[128];
    logic [7:0]    model_mem[128];
    logic [14:0]   wr_log[$];
    logic [AW-1:0] rd_log[$];
    logic [14:0]   exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            excl_viol = 0;
    int            rdy_viol = 0;

    typedef struct {
        int            n;
        logic [7:0]    b[8];
        logic [7:0]    miso[8];
        int            n_wr;
        logic [14:0]   wr[4];
        int            n_rd;
        logic [AW-1:0] rd[4];
    } vec_t;

    // Register file on the bus: read data appears exactly one cycle after reg_rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (bus.reg_wr_en) regs[bus.reg_addr] <= bus.reg_wdata;
        bus.reg_rdata <= bus.reg_rd_en ? regs[bus.reg_addr] : 8'($urandom);
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.reg_wr_en) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
            if (bus.reg_rd_en) rd_log.push_back(bus.reg_addr);
            if (bus.reg_wr_en && bus.reg_rd_en) excl_viol++;
            if (bus.reg_rd_en && bus.spi_ready) rdy_viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.spi_ready, 0);
        check({tag, "_tx"}, bus.spi_tx_data, IDLE_TX);
        check({tag, "_addr"}, bus.reg_addr, 0);
        check({tag, "_wr_en"}, bus.reg_wr_en, 0);
        check({tag, "_rd_en"}, bus.reg_rd_en, 0);
        check({tag, "_wdata"}, bus.reg_wdata, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso, output int waits);
        bus.spi_valid   = 1'b1;
        bus.spi_rx_data = b;
        waits = 0;
        while (!bus.spi_ready && waits < BUDGET) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= BUDGET) check("hs_timeout", bus.spi_ready, 1);
        miso = bus.spi_tx_data;
        @(negedge clk);
        bus.spi_valid   = 1'b0;
        bus.spi_rx_data = 8'($urandom);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_wr_count"}, wr_log.size(), exp_wr_q.size());
        for (int i = 0; i < wr_log.size() && i < exp_wr_q.size(); i++)
            check({tag, "_wr"}, wr_log[i], exp_wr_q[i]);
        check({tag, "_rd_count"}, rd_log.size(), exp_rd_q.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd_q.size(); i++)
            check({tag, "_rd"}, rd_log[i], exp_rd_q[i]);
        wr_log.delete();
        rd_log.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic run_frame(input logic [7:0] fb[8], input int n, input logic [7:0] exp_miso[8],
                             input string tag);
        logic [7:0] m;
        int         w;
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i], m, w);
            check({tag, "_miso"}, m, exp_miso[i]);
            // Read data bytes wait out the fetch and wait cycles; everything else is accepted at once.
            check({tag, "_wait"}, w, (i > 0 && fb[0][7]) ? 2 : 0);
        end
        spi_ss_n = 1'b1;
        repeat (6) @(negedge clk);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_tx_end"}, bus.spi_tx_data, IDLE_TX);
        compare_logs(tag);
    endtask

    // Frame-level protocol model: command byte selects base address and direction.
    task automatic model_frame(input logic [7:0] fb[8], input int n, output logic [7:0] exp_miso[8]);
        logic [6:0] a;
        logic [6:0] idx;
        a = fb[0][6:0];
        for (int k = 0; k < 8; k++) exp_miso[k] = IDLE_TX;
        if (fb[0][7]) exp_rd_q.push_back(a);
        for (int k = 1; k < n; k++) begin
            idx = 7'(int'(a) + k - 1);
            if (fb[0][7]) begin
                exp_miso[k] = model_mem[idx];
                exp_rd_q.push_back(7'(int'(a) + k));
            end else begin
                exp_wr_q.push_back({idx, fb[k]});
                model_mem[idx] = fb[k];
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[3];
        logic [7:0] fb[8];
        logic [7:0] em[8];
        logic [7:0] m;
        int         w;
        int         n;

        for (int i = 0; i < 128; i++) begin
            regs[i]      = 8'($urandom);
            model_mem[i] = regs[i];
        end
        regs[16] = 8'hAB; regs[17] = 8'hCD; regs[18] = 8'hEF;
        model_mem[16] = 8'hAB; model_mem[17] = 8'hCD; model_mem[18] = 8'hEF;

        vecs[0] = '{n: 3, b: '{8'h05, 8'h11, 8'h22, 0, 0, 0, 0, 0},
                    miso: '{IDLE_TX, IDLE_TX, IDLE_TX, 0, 0, 0, 0, 0},
                    n_wr: 2, wr: '{{7'h05, 8'h11}, {7'h06, 8'h22}, 0, 0},
                    n_rd: 0, rd: '{0, 0, 0, 0}};
        vecs[1] = '{n: 4, b: '{8'h90, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0},
                    miso: '{IDLE_TX, 8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0},
                    n_wr: 0, wr: '{0, 0, 0, 0},
                    n_rd: 4, rd: '{7'h10, 7'h11, 7'h12, 7'h13}};
        vecs[2] = '{n: 3, b: '{8'h7F, 8'h01, 8'h02, 0, 0, 0, 0, 0},
                    miso: '{IDLE_TX, IDLE_TX, IDLE_TX, 0, 0, 0, 0, 0},
                    n_wr: 2, wr: '{{7'h7F, 8'h01}, {7'h00, 8'h02}, 0, 0},
                    n_rd: 0, rd: '{0, 0, 0, 0}};

        bus.spi_valid   = 1'b0;
        bus.spi_rx_data = 8'h00;
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_ready", bus.spi_ready, 1);
        check("post_reset_busy", busy, 0);

        // Stale byte with CS high is taken and dropped.
        send_byte(8'h81, m, w);
        repeat (4) @(negedge clk);
        check("stale_busy", busy, 0);
        check("stale_ready", bus.spi_ready, 1);
        compare_logs("stale");

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < vecs[v].n_wr; i++) begin
                exp_wr_q.push_back(vecs[v].wr[i]);
                model_mem[vecs[v].wr[i][14:8]] = vecs[v].wr[i][7:0];
            end
            for (int i = 0; i < vecs[v].n_rd; i++) exp_rd_q.push_back(vecs[v].rd[i]);
            run_frame(vecs[v].b, vecs[v].n, vecs[v].miso, $sformatf("vec%0d", v));
        end

        // Abort right after a read command handshake.
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h83, m, w);
        spi_ss_n = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_latency_ok", (n <= 3) ? 1 : 0, 1);
        check("abort_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("abort_tx", bus.spi_tx_data, IDLE_TX);
        exp_rd_q.push_back(7'h03);
        compare_logs("abort");

        // Reset in the middle of a write burst, then a fresh frame.
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h04, m, w);
        send_byte(8'h77, m, w);
        exp_wr_q.push_back({7'h04, 8'h77});
        model_mem[4] = 8'h77;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rstn     = 1'b1;
        spi_ss_n = 1'b1;
        repeat (4) @(negedge clk);
        compare_logs("midreset_pre");
        fb = '{8'h02, 8'h55, 0, 0, 0, 0, 0, 0};
        model_frame(fb, 2, em);
        run_frame(fb, 2, em, "after_reset");

        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
            model_frame(fb, n, em);
            run_frame(fb, n, em, $sformatf("rand%0d", f));
        end

        check("strobe_exclusive", excl_viol, 0);
        check("ready_during_fetch", rdy_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
